// File: rtl/cpu.sv
// Multicycle RV32I-subset core: FETCH -> DECODE -> EXEC -> (MEM -> (WB)) -> FETCH.
// Harvard buses to synchronous-read instruction and data memories.
module cpu #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic        dmem_write,
  output logic        dmem_read,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] pc_out
);

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;

  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011
  } opcode_t;

  // Declaration initialisers give the same state at power-up as after reset.
  state_t      state = FETCH;
  state_t      state_next;
  logic [31:0] pc = RESET_PC;
  logic [31:0] ir = 32'h0000_0013;
  logic [31:0] addr_reg = '0;
  logic [31:0] regs [0:31] = '{default: '0};

  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val;
  logic        is_lw, is_sw;

  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign funct3 = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_s = {{20{ir[31]}}, ir[31:25], ir[11:7]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_u = {ir[31:12], 12'h000};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};

  assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];

  assign is_lw = (opcode == OP_LOAD)  && (funct3 == 3'b010);
  assign is_sw = (opcode == OP_STORE) && (funct3 == 3'b010);

  assign imem_addr = pc;
  assign pc_out    = pc;

  // ALU shared by OP and OP-IMM; bit 30 selects SUB/SRA only where the ISA defines it.
  logic [31:0] op_b, alu_y;
  logic        alu_alt;
  always_comb begin
    op_b    = (opcode == OP_REG) ? rs2_val : imm_i;
    alu_alt = ir[30] && ((funct3 == 3'b101) ||
                         ((opcode == OP_REG) && (funct3 == 3'b000)));
    alu_y   = '0;
    case (funct3)
      3'b000: alu_y = alu_alt ? rs1_val - op_b : rs1_val + op_b;
      3'b001: alu_y = rs1_val << op_b[4:0];
      3'b010: alu_y = {31'd0, $signed(rs1_val) < $signed(op_b)};
      3'b011: alu_y = {31'd0, rs1_val < op_b};
      3'b100: alu_y = rs1_val ^ op_b;
      3'b101: alu_y = alu_alt ? $unsigned($signed(rs1_val) >>> op_b[4:0])
                              : rs1_val >> op_b[4:0];
      3'b110: alu_y = rs1_val | op_b;
      default: alu_y = rs1_val & op_b;
    endcase
  end

  logic taken;
  always_comb begin
    taken = 1'b0;
    case (funct3)
      3'b000: taken = (rs1_val == rs2_val);
      3'b001: taken = (rs1_val != rs2_val);
      3'b100: taken = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101: taken = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110: taken = (rs1_val <  rs2_val);
      3'b111: taken = (rs1_val >= rs2_val);
      default: taken = 1'b0;
    endcase
  end

  logic [31:0] pc_plus4, pc_next, rd_wdata;
  logic        rd_we;
  assign pc_plus4 = pc + 32'd4;

  always_comb begin
    pc_next  = pc_plus4;
    rd_we    = 1'b0;
    rd_wdata = alu_y;
    case (opcode)
      OP_LUI:   begin rd_we = 1'b1; rd_wdata = imm_u; end
      OP_AUIPC: begin rd_we = 1'b1; rd_wdata = pc + imm_u; end
      OP_JAL:   begin rd_we = 1'b1; rd_wdata = pc_plus4; pc_next = pc + imm_j; end
      OP_JALR: begin
        rd_we    = 1'b1;
        rd_wdata = pc_plus4;
        pc_next  = (rs1_val + imm_i) & 32'hFFFF_FFFE;
      end
      OP_BRANCH: if (taken) pc_next = pc + imm_b;
      OP_IMM, OP_REG: rd_we = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    dmem_write = 1'b0;
    dmem_read  = 1'b0;
    dmem_addr  = '0;
    dmem_wdata = '0;
    case (state)
      FETCH:  state_next = DECODE;
      DECODE: state_next = EXEC;
      EXEC:   state_next = (is_lw || is_sw) ? MEM : FETCH;
      MEM: begin
        dmem_addr = addr_reg;
        if (is_sw) begin
          dmem_write = 1'b1;
          dmem_wdata = rs2_val;
          state_next = FETCH;
        end else begin
          dmem_read  = 1'b1;
          state_next = WB;
        end
      end
      WB:      state_next = FETCH;
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
      for (int unsigned i = 0; i < 32; i++) regs[i[4:0]] <= '0;
    end else begin
      case (state)
        DECODE: ir <= imem_data;
        EXEC: begin
          if (is_lw || is_sw) begin
            addr_reg <= rs1_val + (is_sw ? imm_s : imm_i);
          end else begin
            pc <= pc_next;
            if (rd_we && (rd != 5'd0)) regs[rd] <= rd_wdata;
          end
        end
        MEM: if (is_sw) pc <= pc_plus4;
        WB: begin
          if (rd != 5'd0) regs[rd] <= dmem_rdata;
          pc <= pc_plus4;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu.sv
// Directed bench for cpu: hand-assembled programs, memory models, and a log of dmem strobes.
module tb_cpu;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] imem_addr, imem_data;
  logic        dmem_write, dmem_read;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [31:0] pc_out;

  logic [31:0] imem [0:255];
  logic [31:0] dmem [0:255];

  logic [31:0] wr_addr [$];
  logic [31:0] wr_data [$];
  logic [31:0] rd_addr [$];

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  cpu #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .dmem_write (dmem_write),
    .dmem_read  (dmem_read),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_rdata (dmem_rdata),
    .pc_out     (pc_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) imem_data <= imem[imem_addr[9:2]];

  always @(posedge clk) begin
    if (dmem_write) dmem[dmem_addr[9:2]] <= dmem_wdata;
    dmem_rdata <= dmem[dmem_addr[9:2]];
  end

  always @(negedge clk) begin
    if (dmem_write) begin
      wr_addr.push_back(dmem_addr);
      wr_data.push_back(dmem_wdata);
    end
    if (dmem_read) rd_addr.push_back(dmem_addr);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
    rd_addr.delete();
  endtask

  logic [31:0] exp_wa [0:8] = '{32'd8, 32'd12, 32'd12, 32'd0, 32'd20, 32'd4, 32'd28, 32'd32, 32'd40};
  logic [31:0] exp_wd [0:8] = '{32'h55, 32'h55, 32'h10, 32'hFFFF_FF00, 32'h24,
                                32'h0, 32'hF, 32'hFFFF_FFDD, 32'h1};

  initial begin
    for (int i = 0; i < 256; i++) begin
      imem[i] = 32'h0000_0013;
      dmem[i] = '0;
    end

    // Power-up without reset: NOP stream advances PC by 4 every 3 cycles.
    cyc(1);
    check("powerup pc", pc_out, 32'h0);
    cyc(2);
    check("powerup pc after 1 instr", pc_out, 32'h4);

    // Reset for two cycles, then NOPs.
    reset = 1'b1;
    clear_log();
    cyc(2);
    check("reset pc", pc_out, 32'h0);
    check("reset imem_addr", imem_addr, 32'h0);
    reset = 1'b0;
    cyc(2);
    check("nop pc in exec", pc_out, 32'h0);
    cyc(1);
    check("nop pc +4", pc_out, 32'h4);
    cyc(3);
    check("nop pc +8", pc_out, 32'h8);
    check("nop write strobes", wr_addr.size(), 32'd0);
    check("nop read strobes", rd_addr.size(), 32'd0);

    // Program A: store/load, sign extension, jumps, branches, x0, ALU ops.
    reset = 1'b1;
    imem[0]  = 32'h0550_0093; // addi x1,x0,0x55
    imem[1]  = 32'h0010_2423; // sw   x1,8(x0)
    imem[2]  = 32'h0080_2103; // lw   x2,8(x0)
    imem[3]  = 32'h0020_2623; // sw   x2,12(x0)
    imem[4]  = 32'h0100_0193; // addi x3,x0,16
    imem[5]  = 32'hFE31_AE23; // sw   x3,-4(x3)
    imem[6]  = 32'hFFFF_F237; // lui  x4,0xFFFFF
    imem[7]  = 32'h4042_5293; // srai x5,x4,4
    imem[8]  = 32'h00C0_00EF; // 0x20 jal x1,+12
    imem[9]  = 32'h0010_2A23; // 0x24 sw x1,20(x0)
    imem[10] = 32'h0000_0663; // 0x28 beq x0,x0,+12
    imem[11] = 32'h0050_2023; // 0x2C sw x5,0(x0)
    imem[12] = 32'h0000_8067; // 0x30 jalr x0,0(x1)
    imem[13] = 32'h0050_0013; // 0x34 addi x0,x0,5
    imem[14] = 32'h0000_2223; // 0x38 sw x0,4(x0)
    imem[15] = 32'h0000_0463; // 0x3C beq x0,x0,+8
    imem[16] = 32'h0010_2C23; // 0x40 sw x1,24(x0) (skipped)
    imem[17] = 32'h4010_0333; // 0x44 sub x6,x0,x1
    imem[18] = 32'h0003_23B3; // 0x48 slt x7,x6,x0
    imem[19] = 32'h0063_E4B3; // 0x4C or  x9,x7,x6
    imem[20] = 32'h01C4_D513; // 0x50 srli x10,x9,28
    imem[21] = 32'h00A0_2E23; // 0x54 sw x10,28(x0)
    imem[22] = 32'h0290_2023; // 0x58 sw x9,32(x0)
    imem[23] = 32'h0060_6463; // 0x5C bltu x0,x6,+8
    imem[24] = 32'h0200_2223; // 0x60 sw x0,36(x0) (skipped)
    imem[25] = 32'h0060_4463; // 0x64 blt x0,x6,+8 (not taken)
    imem[26] = 32'h0270_2423; // 0x68 sw x7,40(x0)
    imem[27] = 32'h0000_006F; // 0x6C jal x0,0
    cyc(2);
    clear_log();
    reset = 1'b0;
    cyc(120);
    check("progA write count", wr_addr.size(), 32'd9);
    for (int i = 0; i < 9; i++) begin
      check($sformatf("progA wr%0d addr", i),
            (i < wr_addr.size()) ? wr_addr[i] : 32'hDEAD_BEEF, exp_wa[i]);
      check($sformatf("progA wr%0d data", i),
            (i < wr_data.size()) ? wr_data[i] : 32'hDEAD_BEEF, exp_wd[i]);
    end
    check("progA read count", rd_addr.size(), 32'd1);
    check("progA read addr", (rd_addr.size() > 0) ? rd_addr[0] : 32'hDEAD_BEEF, 32'd8);
    check("progA final pc", pc_out, 32'h6C);

    // Program B: reset asserted while an LW is in MEM.
    reset = 1'b1;
    for (int i = 0; i < 256; i++) imem[i] = 32'h0000_0013;
    imem[0] = 32'h0080_2103; // lw  x2,8(x0)
    imem[1] = 32'h0020_2023; // sw  x2,0(x0)
    imem[2] = 32'h0000_006F; // jal x0,0
    cyc(2);
    clear_log();
    reset = 1'b0;
    cyc(3);
    check("midload dmem_read in MEM", {31'd0, dmem_read}, 32'd1);
    check("midload dmem_addr in MEM", dmem_addr, 32'd8);
    reset = 1'b1;
    cyc(1);
    check("midload pc after reset", pc_out, 32'h0);
    check("midload no read strobe", {31'd0, dmem_read}, 32'd0);
    check("midload no write strobe", {31'd0, dmem_write}, 32'd0);
    check("midload imem_addr", imem_addr, 32'h0);
    reset = 1'b0;
    cyc(20);
    check("progB read count", rd_addr.size(), 32'd2);
    check("progB write count", wr_addr.size(), 32'd1);
    check("progB write addr", (wr_addr.size() > 0) ? wr_addr[0] : 32'hDEAD_BEEF, 32'd0);
    check("progB write data", (wr_data.size() > 0) ? wr_data[0] : 32'hDEAD_BEEF, 32'h55);
    check("progB final pc", pc_out, 32'h8);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
